// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state encodings and defaults for the MIPS run controller
package mips_ctrl_pkg;

  localparam int IMEM_DEPTH_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } state_e;

endpackage

// File: rtl/mips_imem_loader.sv
// rtl/mips_imem_loader.sv - instruction-memory load path: word counter, registered write strobe, overflow flag
module mips_imem_loader
  import mips_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  input  logic        last_i,
  output logic        we_o,
  output logic [31:0] w_ins_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int CW = $clog2(IMEM_DEPTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   w_ins_q, w_ins_d;
  logic          we_q, err_q, err_d;
  logic          accept, overflow;

  always_comb begin
    accept   = en_i && valid_i;
    // Filling the last slot without load_last means the image does not fit.
    overflow = accept && !last_i && (cnt_q == CW'(IMEM_DEPTH - 1));
    done_o   = accept && (last_i || overflow);
    cnt_d    = cnt_q;
    err_d    = err_q;
    w_ins_d  = w_ins_q;
    if (clear_i) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (accept) begin
      cnt_d   = cnt_q + CW'(1);
      w_ins_d = data_i;
      if (overflow) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      w_ins_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= accept;
      w_ins_q <= w_ins_d;
      err_q   <= err_d;
    end
  end

  assign we_o    = we_q;
  assign w_ins_o = w_ins_q;
  assign err_o   = err_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - run/step/halt/load controller for a MIPS core with breakpoint and instruction counter
module mips_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [31:0]      load_data,
  input  logic             load_last,
  output logic             load_ready,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             brk_en,
  input  logic [31:0]      brk_pc,
  input  logic [31:0]      pc,
  output logic             cpu_rst,
  output logic             cpu_we,
  output logic [31:0]      cpu_w_ins,
  output logic             cpu_run,
  output logic [2:0]       state,
  output logic             halted,
  output logic             load_err,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic             skip_brk_q, skip_brk_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             brk_hit, halt_cond, load_entry, load_done;

  always_comb begin
    brk_hit   = brk_en && (pc == brk_pc) && !skip_brk_q;
    halt_cond = halt_req || brk_hit;
    state_d   = state_q;
    cpu_run   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start)    state_d = ST_LOAD;
        else if (step_req) state_d = ST_STEP;
        else if (run_req)  state_d = ST_RUN;
      end
      ST_LOAD: begin
        if (load_done) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (halt_cond) state_d = ST_HALT;
        else           cpu_run = 1'b1;
      end
      ST_STEP: begin
        state_d = ST_HALT;
        cpu_run = !halt_cond;
      end
      ST_HALT: begin
        // A pending breakpoint match must not block resuming from it.
        if (halt_req)        state_d = ST_HALT;
        else if (load_start) state_d = ST_LOAD;
        else if (step_req)   state_d = ST_STEP;
        else if (run_req)    state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (RST) cpu_run = 1'b0;

    load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    skip_brk_d = (state_q == ST_HALT) && ((state_d == ST_RUN) || (state_d == ST_STEP));

    count_d = count_q;
    if (load_entry)                    count_d = '0;
    else if (cpu_run && count_q != '1) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      skip_brk_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      skip_brk_q <= skip_brk_d;
      count_q    <= count_d;
    end
  end

  mips_imem_loader #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_loader (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (state_q == ST_LOAD),
    .clear_i (load_entry),
    .valid_i (load_valid),
    .data_i  (load_data),
    .last_i  (load_last),
    .we_o    (cpu_we),
    .w_ins_o (cpu_w_ins),
    .done_o  (load_done),
    .err_o   (load_err)
  );

  assign state       = state_q;
  assign cpu_rst     = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign load_ready  = (state_q == ST_LOAD);
  assign halted      = (state_q == ST_HALT);
  assign instr_count = count_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb/tb_mips_run_ctrl.sv - scoreboard bench for mips_run_ctrl with directed load/run/step/breakpoint vectors
module tb_mips_run_ctrl;

  localparam int S_STATE = 0, S_RUN = 1, S_HALTED = 2, S_ERR = 3, S_READY = 4;
  localparam int S_CNT = 5, S_CPURST = 6, S_WE = 7, S_WINS = 8, S_WQ_EMPTY = 9;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST, load_start, load_valid, load_last, run_req, step_req, halt_req, brk_en;
  logic [31:0] load_data, brk_pc, pc;
  logic        load_ready, cpu_rst, cpu_we, cpu_run, halted, load_err;
  logic [31:0] cpu_w_ins;
  logic [2:0]  state;
  logic [15:0] instr_count;

  logic [31:0] wq[$];
  exp_t        sq[$];
  int          errors = 0;
  int          checks = 0;

  mips_run_ctrl #(.IMEM_DEPTH(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .brk_en(brk_en), .brk_pc(brk_pc), .pc(pc), .cpu_rst(cpu_rst),
    .cpu_we(cpu_we), .cpu_w_ins(cpu_w_ins), .cpu_run(cpu_run), .state(state),
    .halted(halted), .load_err(load_err), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  // Simple CPU model: PC advances by one word per enabled cycle.
  always @(posedge CLK) begin
    if (cpu_rst)      pc <= 32'h0;
    else if (cpu_run) pc <= pc + 32'd4;
  end

  function automatic logic [31:0] sample(int sig);
    case (sig)
      S_STATE:    return {29'd0, state};
      S_RUN:      return {31'd0, cpu_run};
      S_HALTED:   return {31'd0, halted};
      S_ERR:      return {31'd0, load_err};
      S_READY:    return {31'd0, load_ready};
      S_CNT:      return {16'd0, instr_count};
      S_CPURST:   return {31'd0, cpu_rst};
      S_WE:       return {31'd0, cpu_we};
      S_WINS:     return cpu_w_ins;
      S_WQ_EMPTY: return wq.size();
      default:    return 32'hdead_beef;
    endcase
  endfunction

  initial begin
    exp_t        e;
    logic [31:0] act, w;
    forever begin
      @(negedge CLK);
      if (cpu_we === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL write: unexpected cpu_we with cpu_w_ins=%08h, required no write", cpu_w_ins);
        end else begin
          w = wq.pop_front();
          if (cpu_w_ins !== w) begin
            errors++;
            $display("FAIL write: cpu_w_ins=%08h required %08h", cpu_w_ins, w);
          end
        end
      end
      while (sq.size() > 0) begin
        e   = sq.pop_front();
        act = sample(e.sig);
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %0h required %0h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_sig(string name, int sig, logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    sq.push_back(e);
  endtask

  task automatic expect_reset(string tag);
    expect_sig({tag, "_state"}, S_STATE, 0);
    expect_sig({tag, "_cpu_rst"}, S_CPURST, 1);
    expect_sig({tag, "_cpu_we"}, S_WE, 0);
    expect_sig({tag, "_cpu_w_ins"}, S_WINS, 0);
    expect_sig({tag, "_cpu_run"}, S_RUN, 0);
    expect_sig({tag, "_load_ready"}, S_READY, 0);
    expect_sig({tag, "_halted"}, S_HALTED, 0);
    expect_sig({tag, "_load_err"}, S_ERR, 0);
    expect_sig({tag, "_instr_count"}, S_CNT, 0);
  endtask

  logic [31:0] prog [3];
  logic [31:0] ovf  [5];

  initial begin
    prog[0] = 32'h2008_0005; prog[1] = 32'h2009_0003; prog[2] = 32'h0109_5020;
    ovf[0] = 32'hA000_0001; ovf[1] = 32'hA000_0002; ovf[2] = 32'hA000_0003;
    ovf[3] = 32'hA000_0004; ovf[4] = 32'hA000_0005;
    RST = 1'b1; load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
    run_req = 0; step_req = 0; halt_req = 0; brk_en = 0; brk_pc = 0;
    tick(); tick();
    expect_reset("reset");
    tick();
    RST = 1'b0;

    // Three-word load terminated by load_last
    load_start = 1; tick(); load_start = 0;
    expect_sig("load_state", S_STATE, 1);
    expect_sig("load_ready", S_READY, 1);
    expect_sig("load_cpu_rst", S_CPURST, 1);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = prog[i]; load_last = (i == 2);
      wq.push_back(prog[i]);
      tick();
    end
    load_valid = 0; load_last = 0;
    expect_sig("load_done_state", S_STATE, 0);
    expect_sig("load_done_err", S_ERR, 0);
    expect_sig("load_done_ready", S_READY, 0);
    tick();
    expect_sig("load_write_count", S_WQ_EMPTY, 0);

    // Five words into a four-word memory without load_last
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1; load_data = ovf[i];
      if (i < 4) wq.push_back(ovf[i]);
      if (i == 4) begin
        expect_sig("ovf_state", S_STATE, 0);
        expect_sig("ovf_err", S_ERR, 1);
        expect_sig("ovf_ready", S_READY, 0);
      end
      tick();
    end
    load_valid = 0;
    tick();
    expect_sig("ovf_write_count", S_WQ_EMPTY, 0);

    // Run ten cycles, then halt_req
    run_req = 1; tick(); run_req = 0;
    expect_sig("run_state", S_STATE, 2);
    expect_sig("run_cpu_run", S_RUN, 1);
    expect_sig("run_cpu_rst", S_CPURST, 0);
    repeat (10) tick();
    halt_req = 1;
    expect_sig("halt_req_cpu_run", S_RUN, 0);
    expect_sig("halt_req_count", S_CNT, 10);
    tick(); halt_req = 0;
    expect_sig("halt_state", S_STATE, 4);
    expect_sig("halt_halted", S_HALTED, 1);
    expect_sig("halt_count", S_CNT, 10);

    // Breakpoint at 0x8 from pc=0, then resume past it
    RST = 1; tick(); RST = 0;
    brk_en = 1; brk_pc = 32'h8;
    run_req = 1; tick(); run_req = 0;
    tick(); tick();
    expect_sig("brk_cpu_run", S_RUN, 0);
    tick();
    expect_sig("brk_state", S_STATE, 4);
    expect_sig("brk_count", S_CNT, 2);
    run_req = 1; tick(); run_req = 0;
    expect_sig("resume_cpu_run", S_RUN, 1);
    tick();
    halt_req = 1; tick(); halt_req = 0;
    expect_sig("resume_halt_count", S_CNT, 3);

    // step_req suppressed by simultaneous halt_req, then a lone step
    step_req = 1; halt_req = 1;
    expect_sig("step_halt_cpu_run", S_RUN, 0);
    tick(); step_req = 0; halt_req = 0;
    expect_sig("step_halt_state", S_STATE, 4);
    expect_sig("step_halt_cpu_run2", S_RUN, 0);
    step_req = 1; tick(); step_req = 0;
    expect_sig("step_state", S_STATE, 3);
    expect_sig("step_cpu_run", S_RUN, 1);
    tick();
    expect_sig("step_after_state", S_STATE, 4);
    expect_sig("step_after_cpu_run", S_RUN, 0);
    expect_sig("step_count", S_CNT, 4);
    tick();
    expect_sig("step_once_cpu_run", S_RUN, 0);

    // Reset during the second load word
    load_start = 1; tick(); load_start = 0;
    expect_sig("reload_count_clear", S_CNT, 0);
    load_valid = 1; load_data = 32'hB000_0001; wq.push_back(32'hB000_0001);
    tick();
    load_data = 32'hB000_0002; RST = 1;
    tick();
    expect_reset("rst_mid_load");
    RST = 0; load_valid = 0;
    tick();
    tick();
    expect_sig("rst_load_write_count", S_WQ_EMPTY, 0);
    tick();
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
